// File: rtl/spike_window_accumulator_pkg.sv
// Shared sizing helpers and constants for the spike window accumulator.
// Also provides the index helper used to slice one synapse's weight from the packed bus.
package spike_window_accumulator_pkg;

    localparam int unsigned DEF_N_IN     = 4;
    localparam int unsigned DEF_W_WIDTH  = 4;
    localparam int unsigned DEF_WIN_BITS = 4;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    // Wide enough that a full window of all-max weights cannot wrap.
    function automatic int unsigned acc_width(input int unsigned n_in,
                                              input int unsigned w_width,
                                              input int unsigned win_bits);
        return w_width + win_bits + clog2(n_in);
    endfunction

    function automatic int unsigned win_max(input int unsigned win_bits);
        return (32'd1 << win_bits) - 32'd1;
    endfunction

    function automatic int unsigned wslice_lo(input int unsigned idx,
                                              input int unsigned w_width);
        return idx * w_width;
    endfunction

endpackage

// File: rtl/spike_weight_adder.sv
// Combinational weighted pulse sum: adds weight[i] for every asserted pulse bit.
module spike_weight_adder
    import spike_window_accumulator_pkg::*;
#(
    parameter int unsigned N_IN      = DEF_N_IN,
    parameter int unsigned W_WIDTH   = DEF_W_WIDTH,
    parameter int unsigned ACC_WIDTH = acc_width(DEF_N_IN, DEF_W_WIDTH, DEF_WIN_BITS)
) (
    input  logic [N_IN-1:0]         pulse,
    input  logic [N_IN*W_WIDTH-1:0] weight,
    output logic [ACC_WIDTH-1:0]    contrib
);

    always_comb begin
        contrib = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (pulse[i]) begin
                contrib = contrib + ACC_WIDTH'(weight[wslice_lo(i, W_WIDTH) +: W_WIDTH]);
            end
        end
    end

endmodule

// File: rtl/spike_window_accumulator.sv
// Accumulates weighted pulses over a window of enabled cycles and offers the
// window sum plus a threshold fire flag through a valid/ready output slot.
module spike_window_accumulator
    import spike_window_accumulator_pkg::*;
#(
    parameter int unsigned N_IN      = DEF_N_IN,
    parameter int unsigned W_WIDTH   = DEF_W_WIDTH,
    parameter int unsigned WIN_BITS  = DEF_WIN_BITS,
    parameter int unsigned ACC_WIDTH = acc_width(N_IN, W_WIDTH, WIN_BITS)
) (
    input  logic                    clock,
    input  logic                    res,
    input  logic                    en,
    input  logic [N_IN-1:0]         pulse_in,
    input  logic [N_IN*W_WIDTH-1:0] weight,
    input  logic [ACC_WIDTH-1:0]    threshold,
    input  logic                    out_ready,
    input  logic                    clear_ovr,
    output logic [ACC_WIDTH-1:0]    sum_out,
    output logic                    fire,
    output logic                    out_valid,
    output logic                    overrun
);

    logic [WIN_BITS-1:0]  win_cnt;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] contrib;
    logic [ACC_WIDTH-1:0] result;
    logic                 complete;
    logic                 slot_free;

    spike_weight_adder #(
        .N_IN      (N_IN),
        .W_WIDTH   (W_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_adder (
        .pulse   (pulse_in),
        .weight  (weight),
        .contrib (contrib)
    );

    always_comb begin
        result    = acc + contrib;
        complete  = en && (win_cnt == WIN_BITS'(win_max(WIN_BITS)));
        // An accept on the same edge frees the slot for the new result.
        slot_free = !out_valid || out_ready;
    end

    always_ff @(posedge clock or posedge res) begin
        if (res) begin
            win_cnt   <= '0;
            acc       <= '0;
            sum_out   <= '0;
            fire      <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (en) begin
                win_cnt <= win_cnt + 1'b1;
                acc     <= complete ? '0 : result;
            end

            if (complete && slot_free) begin
                sum_out   <= result;
                fire      <= (result >= threshold);
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (complete && !slot_free) begin
                overrun <= 1'b1;
            end else if (clear_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/spike_window_accumulator.md
Name: spike_window_accumulator

Overview:
- Downstream stage of the counter/compare pulse generator: consumes the per-input pulse streams (one bit per synapse) it produces.
- Accumulates weighted pulses over a fixed window of 2^WIN_BITS enabled cycles, then registers the neuron pre-activation sum and a threshold fire flag.
- Result leaves through a valid/ready handshake to the activation/next-layer stage.

Parameters:
- N_IN, 4, number of synapse pulse inputs.
- W_WIDTH, 4, unsigned weight width per synapse.
- WIN_BITS, 4, window length = 2^WIN_BITS enabled cycles (16).
- ACC_WIDTH, W_WIDTH+WIN_BITS+clog2(N_IN) = 10, accumulator/result width (derived; never overflows).

Ports:
- clock  in  1  system clock, rising edge.
- res  in  1  asynchronous, active-high reset.
- en  in  1  sample enable; low freezes window counter and accumulator.
- pulse_in  in  N_IN  pulse bits from compare stage, sampled when en=1.
- weight  in  N_IN*W_WIDTH  packed unsigned weights; weight[i] at bits [i*W_WIDTH +: W_WIDTH].
- threshold  in  ACC_WIDTH  fire threshold, sampled at window completion.
- out_ready  in  1  downstream accepts result.
- clear_ovr  in  1  clears overrun flag.
- sum_out  out  ACC_WIDTH  registered window sum.
- fire  out  1  registered (sum_out >= threshold).
- out_valid  out  1  result held valid until accepted.
- overrun  out  1  sticky: a window completed while the previous result was unaccepted.

Behaviour:
- Reset (res=1, async): win_cnt, acc, sum_out, fire, out_valid, overrun all 0. Reset mid-window discards partial sum; next window needs a full 2^WIN_BITS enabled cycles.
- Per enabled cycle: contrib = sum over i of (pulse_in[i] ? weight[i] : 0), zero-extended to ACC_WIDTH; win_cnt increments modulo 2^WIN_BITS.
- Non-final enabled cycle (win_cnt != max): acc <= acc + contrib.
- Final enabled cycle (win_cnt == max): result = acc + contrib; acc <= 0; win_cnt wraps to 0; completion event.
- Latency: out_valid rises on the clock edge that samples the 16th enabled cycle; sum_out/fire valid the same edge.
- Handshake: transfer when out_valid && out_ready at a rising edge; out_valid then drops unless a new completion loads in that same edge.
- Completion with slot free (out_valid=0, or out_valid=1 and out_ready=1 same cycle): load sum_out=result, fire=(result>=threshold), out_valid=1.
- Completion with slot occupied (out_valid=1, out_ready=0): new result dropped, held result unchanged, overrun <= 1.
- overrun cleared by clear_ovr=1; if clear_ovr and a new overrun coincide, overrun stays 1 (set wins).
- en=0: win_cnt, acc hold; handshake and clear_ovr still operate.
- Weights/threshold not registered; must be stable during window (weights) and at completion (threshold).
- Arithmetic unsigned; ACC_WIDTH guarantees no wrap (max N_IN*(2^W_WIDTH-1)*2^WIN_BITS = 960 < 1024 at defaults).

Decomposition:
- Shared package: derived ACC_WIDTH computation, window-max constant, clog2 function, weight-slice indexing helper.
- One sub-module: spike_weight_adder (combinational N_IN-way weighted pulse sum, output ACC_WIDTH); rest is a single sequential block.

Test Plan:
- pulse_in=4'b0001 constant, weight0=3, threshold=40, en=1, out_ready=1 -> after 16 cycles sum_out=48, fire=1, out_valid pulses 1 cycle.
- pulse_in=4'b1111, all weights=15, threshold=961 -> sum_out=960, fire=0, no wrap.
- out_ready=0 across two windows (first sum 48, second 96) -> sum_out stays 48, overrun=1; clear_ovr pulse -> overrun=0.
- en high 8 cycles, low 4, high 8, pulse_in=4'b0010, weight1=2 -> out_valid only after 16th enabled cycle, sum_out=32.
- res asserted after 10 cycles of accumulation -> all outputs 0 immediately; next result requires 16 fresh cycles, sum matches fresh data only.
- out_valid=1 held, out_ready=1 asserted exactly on next completion edge -> out_valid stays 1, sum_out updates to new value, overrun=0.
